// File: rtl/gshare_predictor.sv
// gshare direction predictor: PC^GHR indexed PHT of saturating counters with
// one-cycle registered lookup, execute-side training and mispredict GHR repair.
module gshare_predictor #(
    parameter int unsigned       PC_W     = 14,
    parameter int unsigned       IDX_W    = 12,
    parameter int unsigned       HIST_W   = 12,
    parameter int unsigned       CTR_W    = 2,
    parameter logic [CTR_W-1:0]  CTR_INIT = 2'b10
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              f_valid,
    input  logic [PC_W-1:0]   f_pc,
    output logic              pred_valid,
    output logic              pred_taken,
    output logic [IDX_W-1:0]  pred_idx,
    output logic [HIST_W-1:0] pred_ghr,
    input  logic              upd_valid,
    input  logic [IDX_W-1:0]  upd_idx,
    input  logic              upd_taken,
    input  logic              upd_mispredict,
    input  logic [HIST_W-1:0] upd_ghr,
    output logic              init_done,
    output logic [31:0]       mispred_cnt
);
    localparam int unsigned DEPTH = 1 << IDX_W;

    typedef enum logic {INIT, RUN} state_t;

    state_t             state, state_next;
    logic [IDX_W-1:0]   ptr;
    logic [HIST_W-1:0]  ghr, ghr_next;
    logic [CTR_W-1:0]   pht [DEPTH];

    logic               run, flush, lookup;
    logic [IDX_W-1:0]   idx;
    logic [CTR_W-1:0]   cur_ctr, upd_ctr;
    logic               pht_we;
    logic [IDX_W-1:0]   pht_waddr;
    logic [CTR_W-1:0]   pht_wdata;
    logic               unused_pc;

    assign run       = (state == RUN);
    assign init_done = run;
    assign flush     = run & upd_valid & upd_mispredict;
    assign lookup    = run & f_valid & ~flush;
    assign idx       = f_pc[IDX_W+1:2] ^ IDX_W'(ghr);
    assign unused_pc = ^f_pc;

    always_comb begin
        state_next = state;
        if (state == INIT && ptr == '1)
            state_next = RUN;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= INIT;
            ptr   <= '0;
        end else begin
            state <= state_next;
            if (state == INIT)
                ptr <= ptr + 1'b1;
        end
    end

    always_comb begin
        cur_ctr = pht[upd_idx];
        upd_ctr = cur_ctr;
        if (upd_taken) begin
            if (cur_ctr != '1)
                upd_ctr = cur_ctr + 1'b1;
        end else if (cur_ctr != '0) begin
            upd_ctr = cur_ctr - 1'b1;
        end
    end

    // Single write port shared by the init sweep and execute training.
    always_comb begin
        pht_we    = 1'b0;
        pht_waddr = ptr;
        pht_wdata = CTR_INIT;
        if (!run) begin
            pht_we = 1'b1;
        end else if (upd_valid) begin
            pht_we    = 1'b1;
            pht_waddr = upd_idx;
            pht_wdata = upd_ctr;
        end
    end

    always_ff @(posedge clk) begin
        if (pht_we)
            pht[pht_waddr] <= pht_wdata;
    end

    // Recovery wins over the speculative shift of a prediction shown this cycle.
    always_comb begin
        ghr_next = ghr;
        if (!run)
            ghr_next = '0;
        else if (flush)
            ghr_next = HIST_W'({upd_ghr, upd_taken});
        else if (pred_valid)
            ghr_next = HIST_W'({ghr, pred_taken});
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ghr         <= '0;
            pred_valid  <= 1'b0;
            pred_taken  <= 1'b0;
            pred_idx    <= '0;
            pred_ghr    <= '0;
            mispred_cnt <= '0;
        end else begin
            ghr        <= ghr_next;
            pred_valid <= lookup;
            if (lookup) begin
                pred_taken <= pht[idx][CTR_W-1];
                pred_idx   <= idx;
                pred_ghr   <= ghr;
            end
            if (flush && mispred_cnt != '1)
                mispred_cnt <= mispred_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_gshare_predictor.sv
// Self-checking bench for gshare_predictor: directed vector table, randomized
// traffic against a behavioural model, and reset/sweep timing checks.
module tb_gshare_predictor;
    localparam int DEPTH = 4096;

    logic        clk = 1'b0;
    logic        rst;
    logic        f_valid;
    logic [13:0] f_pc;
    logic        pred_valid;
    logic        pred_taken;
    logic [11:0] pred_idx;
    logic [11:0] pred_ghr;
    logic        upd_valid;
    logic [11:0] upd_idx;
    logic        upd_taken;
    logic        upd_mispredict;
    logic [11:0] upd_ghr;
    logic        init_done;
    logic [31:0] mispred_cnt;

    int errors = 0;
    int checks = 0;

    gshare_predictor #(
        .PC_W(14), .IDX_W(12), .HIST_W(12), .CTR_W(2), .CTR_INIT(2'b10)
    ) dut (
        .clk(clk), .rst(rst),
        .f_valid(f_valid), .f_pc(f_pc),
        .pred_valid(pred_valid), .pred_taken(pred_taken),
        .pred_idx(pred_idx), .pred_ghr(pred_ghr),
        .upd_valid(upd_valid), .upd_idx(upd_idx), .upd_taken(upd_taken),
        .upd_mispredict(upd_mispredict), .upd_ghr(upd_ghr),
        .init_done(init_done), .mispred_cnt(mispred_cnt)
    );

    always #5 clk = ~clk;

    // Behavioural model: table of counters, history, the pending response.
    int          m_pht [DEPTH];
    int          m_ghr;
    bit          m_pv, m_pt;
    int          m_pidx, m_pghr;
    int unsigned m_cnt;

    typedef struct {
        bit fv; int pc; bit uv; int uidx; bit ut; bit um; int ughr;
        bit ev; bit et; int eidx; int eghr; int ecnt;
    } vec_t;
    vec_t vecs[25];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < DEPTH; i++) m_pht[i] = 2;
        m_ghr = 0; m_pv = 0; m_pt = 0; m_pidx = 0; m_pghr = 0; m_cnt = 0;
    endtask

    task automatic model_step(input bit fv, input int pc, input bit uv, input int uidx,
                              input bit ut, input bit um, input int ughr);
        bit flush, shown_v, shown_t;
        int hist, i;
        flush   = uv && um;
        shown_v = m_pv;
        shown_t = m_pt;
        hist    = m_ghr;
        if (fv && !flush) begin
            i      = ((pc >> 2) % DEPTH) ^ hist;
            m_pv   = 1;
            m_pt   = (m_pht[i] >= 2);
            m_pidx = i;
            m_pghr = hist;
        end else begin
            m_pv = 0;
        end
        if (uv) begin
            if (ut) m_pht[uidx] = (m_pht[uidx] == 3) ? 3 : m_pht[uidx] + 1;
            else    m_pht[uidx] = (m_pht[uidx] == 0) ? 0 : m_pht[uidx] - 1;
        end
        if (flush)        m_ghr = (ughr * 2 + int'(ut)) % DEPTH;
        else if (shown_v) m_ghr = (hist * 2 + int'(shown_t)) % DEPTH;
        if (flush && m_cnt != 32'hFFFF_FFFF) m_cnt++;
    endtask

    task automatic drive(input bit fv, input int pc, input bit uv, input int uidx,
                         input bit ut, input bit um, input int ughr);
        f_valid = fv; f_pc = 14'(pc);
        upd_valid = uv; upd_idx = 12'(uidx); upd_taken = ut;
        upd_mispredict = um; upd_ghr = 12'(ughr);
        model_step(fv, pc, uv, uidx, ut, um, ughr);
        @(posedge clk); #1;
    endtask

    task automatic idle_inputs();
        f_valid = 0; f_pc = '0; upd_valid = 0; upd_idx = '0;
        upd_taken = 0; upd_mispredict = 0; upd_ghr = '0;
    endtask

    task automatic check_reset_values(input string tag);
        chk({tag, " pred_valid"}, 32'(pred_valid), 0);
        chk({tag, " pred_taken"}, 32'(pred_taken), 0);
        chk({tag, " pred_idx"}, 32'(pred_idx), 0);
        chk({tag, " pred_ghr"}, 32'(pred_ghr), 0);
        chk({tag, " init_done"}, 32'(init_done), 0);
        chk({tag, " mispred_cnt"}, mispred_cnt, 0);
    endtask

    // Runs from the first edge with reset high until init_done, with junk traffic.
    task automatic sweep(output int rise_at, output int pv_seen);
        rise_at = 0;
        pv_seen = 0;
        for (int n = 1; n <= 5000; n++) begin
            f_valid = 1'($urandom); f_pc = 14'($urandom);
            upd_valid = 1'($urandom); upd_idx = 12'($urandom);
            upd_taken = 1'($urandom); upd_mispredict = 1; upd_ghr = 12'($urandom);
            @(posedge clk); #1;
            if (pred_valid) pv_seen++;
            if (init_done) begin
                rise_at = n;
                break;
            end
        end
        idle_inputs();
    endtask

    initial begin
        int rise_at, pv_seen;

        // fv pc uv uidx ut um ughr | ev et eidx eghr ecnt
        vecs[0]  = '{1, 'h040, 0, 0,     0, 0, 0,     1, 1, 'h010, 'h000, 0};
        vecs[1]  = '{0, 0,     0, 0,     0, 0, 0,     0, 0, 0,     0,     0};
        vecs[2]  = '{1, 'h040, 0, 0,     0, 0, 0,     1, 1, 'h011, 'h001, 0};
        vecs[3]  = '{0, 0,     0, 0,     0, 0, 0,     0, 0, 0,     0,     0};
        vecs[4]  = '{0, 0,     1, 'h010, 0, 0, 0,     0, 0, 0,     0,     0};
        vecs[5]  = '{0, 0,     1, 'h010, 0, 0, 0,     0, 0, 0,     0,     0};
        vecs[6]  = '{0, 0,     1, 'h010, 0, 0, 0,     0, 0, 0,     0,     0};
        vecs[7]  = '{1, 'h04C, 0, 0,     0, 0, 0,     1, 0, 'h010, 'h003, 0};
        vecs[8]  = '{0, 0,     0, 0,     0, 0, 0,     0, 0, 0,     0,     0};
        vecs[9]  = '{0, 0,     1, 'h010, 1, 0, 0,     0, 0, 0,     0,     0};
        vecs[10] = '{0, 0,     1, 'h010, 1, 0, 0,     0, 0, 0,     0,     0};
        vecs[11] = '{0, 0,     1, 'h010, 1, 0, 0,     0, 0, 0,     0,     0};
        vecs[12] = '{0, 0,     1, 'h010, 1, 0, 0,     0, 0, 0,     0,     0};
        vecs[13] = '{0, 0,     1, 'h010, 0, 0, 0,     0, 0, 0,     0,     0};
        vecs[14] = '{1, 'h058, 0, 0,     0, 0, 0,     1, 1, 'h010, 'h006, 0};
        vecs[15] = '{0, 0,     0, 0,     0, 0, 0,     0, 0, 0,     0,     0};
        vecs[16] = '{0, 0,     1, 'h020, 0, 0, 0,     0, 0, 0,     0,     0};
        vecs[17] = '{1, 'h0B4, 1, 'h020, 1, 0, 0,     1, 0, 'h020, 'h00D, 0};
        vecs[18] = '{1, 'h0B4, 0, 0,     0, 0, 0,     1, 1, 'h020, 'h00D, 0};
        vecs[19] = '{0, 0,     0, 0,     0, 0, 0,     0, 0, 0,     0,     0};
        vecs[20] = '{1, 'h040, 1, 'h100, 1, 1, 'h0A5, 0, 0, 0,     0,     1};
        vecs[21] = '{1, 'h000, 0, 0,     0, 0, 0,     1, 1, 'h14B, 'h14B, 1};
        vecs[22] = '{0, 0,     1, 'h200, 0, 1, 'h003, 0, 0, 0,     0,     2};
        vecs[23] = '{1, 'h000, 0, 0,     0, 0, 0,     1, 1, 'h006, 'h006, 2};
        vecs[24] = '{0, 0,     0, 0,     0, 0, 0,     0, 0, 0,     0,     2};

        idle_inputs();
        rst = 0;
        repeat (2) @(posedge clk);
        #1;
        check_reset_values("reset");

        rst = 1;
        sweep(rise_at, pv_seen);
        chk("init_done_latency", rise_at, DEPTH);
        chk("pred_valid_during_init", pv_seen, 0);
        chk("mispred_cnt_after_init", mispred_cnt, 0);

        model_reset();
        foreach (vecs[i]) begin
            drive(vecs[i].fv, vecs[i].pc, vecs[i].uv, vecs[i].uidx,
                  vecs[i].ut, vecs[i].um, vecs[i].ughr);
            chk($sformatf("row%0d pred_valid", i), 32'(pred_valid), 32'(vecs[i].ev));
            if (vecs[i].ev) begin
                chk($sformatf("row%0d pred_taken", i), 32'(pred_taken), 32'(vecs[i].et));
                chk($sformatf("row%0d pred_idx", i), 32'(pred_idx), vecs[i].eidx);
                chk($sformatf("row%0d pred_ghr", i), 32'(pred_ghr), vecs[i].eghr);
            end
            chk($sformatf("row%0d mispred_cnt", i), mispred_cnt, vecs[i].ecnt);
        end

        for (int n = 0; n < 2000; n++) begin
            bit uv;
            uv = ($urandom_range(0, 2) == 0);
            drive(1'($urandom), $urandom_range(0, 255), uv, $urandom_range(0, 63),
                  1'($urandom), uv && ($urandom_range(0, 7) == 0), $urandom_range(0, DEPTH - 1));
            chk($sformatf("rand%0d pred_valid", n), 32'(pred_valid), 32'(m_pv));
            if (m_pv) begin
                chk($sformatf("rand%0d pred_taken", n), 32'(pred_taken), 32'(m_pt));
                chk($sformatf("rand%0d pred_idx", n), 32'(pred_idx), m_pidx);
                chk($sformatf("rand%0d pred_ghr", n), 32'(pred_ghr), m_pghr);
            end
            chk($sformatf("rand%0d mispred_cnt", n), mispred_cnt, m_cnt);
        end
        idle_inputs();

        rst = 0;
        #1;
        check_reset_values("midrun_reset");
        @(posedge clk); #1;
        rst = 1;
        for (int n = 0; n < 100; n++) begin
            f_valid = 1'($urandom); f_pc = 14'($urandom);
            @(posedge clk); #1;
        end
        idle_inputs();
        rst = 0;
        #1;
        check_reset_values("midsweep_reset");
        @(posedge clk); #1;
        rst = 1;
        sweep(rise_at, pv_seen);
        chk("resweep_init_done_latency", rise_at, DEPTH);
        chk("resweep_pred_valid_during_init", pv_seen, 0);

        model_reset();
        drive(1, 'h040, 0, 0, 0, 0, 0);
        chk("post_resweep pred_valid", 32'(pred_valid), 1);
        chk("post_resweep pred_taken", 32'(pred_taken), 1);
        chk("post_resweep pred_idx", 32'(pred_idx), 'h010);
        chk("post_resweep pred_ghr", 32'(pred_ghr), 0);
        idle_inputs();
        @(posedge clk); #1;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
